btn_sw_conditioner: RTL

- Board-side receiver for the push-button and slide-switch inputs that the bench drives into the top level. The block synchronises and debounces each raw input and produces clean levels, single-cycle edge pulses, and a valid/ready event stream.
- The LED/LFSR/FIFO logic consumes its outputs.
- Sits directly behind the top-level btn/sw pins.

---
 rtl/btn_sw_conditioner.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/btn_sw_conditioner.sv
// Button/switch input conditioner: per-channel synchroniser and debouncer,
// registered edge pulses, and a backpressured event stream that reports the
// lowest-index channel with an unreported debounced change.
module btn_sw_conditioner #(
    parameter int NUM_BTN         = 2,
    parameter int NUM_SW          = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    localparam int NCH            = NUM_BTN + NUM_SW,
    localparam int ID_W           = $clog2(NCH),
    localparam int CNT_W          = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_BTN-1:0] btn,
    input  logic [NUM_SW-1:0]  sw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_SW-1:0]  sw_level,
    output logic [NUM_SW-1:0]  sw_change,
    output logic               event_valid,
    input  logic               event_ready,
    output logic [ID_W-1:0]    event_id,
    output logic               event_level,
    output logic               event_overflow,
    input  logic               overflow_clr
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Buttons occupy the low channel indices, switches follow.
    logic [NCH-1:0] raw;
    logic [NCH-1:0] sync_s;

    logic [SYNC_STAGES-1:0][NCH-1:0] sync_q, sync_d;
    logic [NCH-1:0][CNT_W-1:0]       cnt_q, cnt_d;
    logic [NCH-1:0]                  level_q, level_d;
    logic [NCH-1:0]                  strobe;

    logic [NUM_BTN-1:0] press_q, press_d;
    logic [NUM_BTN-1:0] release_q, release_d;
    logic [NUM_SW-1:0]  change_q, change_d;

    logic [NCH-1:0]  pend_q, pend_d;
    logic [NCH-1:0]  pend_clr;
    logic [NCH-1:0]  sel_oh;
    logic [ID_W-1:0] sel_id;
    logic            sel_level;
    logic            found;
    logic            load;
    logic            ev_valid_q, ev_valid_d;
    logic [ID_W-1:0] ev_id_q, ev_id_d;
    logic            ev_level_q, ev_level_d;
    logic            ovf_q, ovf_d;
    logic            ovf_set;

    assign raw    = {sw, btn};
    assign sync_s = sync_q[SYNC_STAGES-1];

    // Shift each raw input through a plain flop chain to tame metastability.
    always_comb begin
        sync_d[0] = raw;
        for (int st = 1; st < SYNC_STAGES; st++) begin
            sync_d[st] = sync_q[st-1];
        end
    end

    // Accept a new level only after it has differed from the stable one long enough.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        strobe  = '0;
        for (int i = 0; i < NCH; i++) begin
            if (sync_s[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                level_d[i] = sync_s[i];
                cnt_d[i]   = '0;
                strobe[i]  = 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    // Edge pulses are the strobe qualified by the direction of the new level.
    always_comb begin
        press_d   = strobe[NUM_BTN-1:0] & sync_s[NUM_BTN-1:0];
        release_d = strobe[NUM_BTN-1:0] & ~sync_s[NUM_BTN-1:0];
        change_d  = strobe[NCH-1:NUM_BTN];
    end

    // Pick the lowest-index pending channel and its current stable level.
    always_comb begin
        found     = 1'b0;
        sel_id    = '0;
        sel_level = 1'b0;
        sel_oh    = '0;
        for (int i = 0; i < NCH; i++) begin
            if (!found && pend_q[i]) begin
                found     = 1'b1;
                sel_id    = ID_W'(i);
                sel_level = level_q[i];
                sel_oh[i] = 1'b1;
            end
        end
    end

    // Event register, pending mask and sticky overflow; a new strobe beats a clear.
    always_comb begin
        load       = !ev_valid_q || event_ready;
        ev_valid_d = ev_valid_q;
        ev_id_d    = ev_id_q;
        ev_level_d = ev_level_q;
        pend_clr   = '0;
        if (load) begin
            ev_valid_d = found;
            if (found) begin
                ev_id_d    = sel_id;
                ev_level_d = sel_level;
                pend_clr   = sel_oh;
            end
        end
        pend_d  = (pend_q & ~pend_clr) | strobe;
        ovf_set = |(strobe & pend_q & ~pend_clr);
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (overflow_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // All state registers share the asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q     <= '0;
            cnt_q      <= '0;
            level_q    <= '0;
            press_q    <= '0;
            release_q  <= '0;
            change_q   <= '0;
            pend_q     <= '0;
            ev_valid_q <= 1'b0;
            ev_id_q    <= '0;
            ev_level_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            cnt_q      <= cnt_d;
            level_q    <= level_d;
            press_q    <= press_d;
            release_q  <= release_d;
            change_q   <= change_d;
            pend_q     <= pend_d;
            ev_valid_q <= ev_valid_d;
            ev_id_q    <= ev_id_d;
            ev_level_q <= ev_level_d;
            ovf_q      <= ovf_d;
        end
    end

    assign btn_level      = level_q[NUM_BTN-1:0];
    assign sw_level       = level_q[NCH-1:NUM_BTN];
    assign btn_press      = press_q;
    assign btn_release    = release_q;
    assign sw_change      = change_q;
    assign event_valid    = ev_valid_q;
    assign event_id       = ev_id_q;
    assign event_level    = ev_level_q;
    assign event_overflow = ovf_q;

endmodule
